// File: rtl/sec08_queues_pkg.sv
// Shared constants and helpers for the queue arbiter slice.
package sec08_queues_pkg;

  localparam int c_def_nreqs     = 4;
  localparam int c_def_msg_nbits = 32;

  // Width of the source-id field; one bit minimum so a 2-requester build still tags messages.
  function automatic int src_nbits(input int nreqs);
    return (nreqs <= 2) ? 1 : $clog2(nreqs);
  endfunction

endpackage

// File: rtl/sec08_queues_Buf2.sv
// Two-entry normal FIFO. Handshake: a transfer happens on a rising clk edge where
// val and rdy are both high on the same side; enq_rdy depends only on occupancy,
// never on deq_rdy, so a full buffer refuses input even while it is draining.
module sec08_queues_Buf2
  import sec08_queues_pkg::*;
#(
  parameter int p_nbits = src_nbits(c_def_nreqs) + c_def_msg_nbits
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_val,
  output logic               enq_rdy,
  input  logic [p_nbits-1:0] enq_msg,
  output logic               deq_val,
  input  logic               deq_rdy,
  output logic [p_nbits-1:0] deq_msg,
  output logic [1:0]         num_entries
);

  logic [p_nbits-1:0] r_mem [2];
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [1:0]         r_count;
  logic               w_enq;
  logic               w_deq;

  // Handshake and status outputs; reset gates enq_rdy so nothing is offered while reset is high.
  always_comb begin
    enq_rdy     = (r_count != 2'd2) && !reset;
    deq_val     = (r_count != 2'd0);
    deq_msg     = r_mem[r_rd_ptr];
    num_entries = r_count;
    w_enq       = enq_val && enq_rdy;
    w_deq       = deq_val && deq_rdy;
  end

  // Storage, pointers and occupancy; reset discards any buffered entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_enq) begin
        r_mem[r_wr_ptr] <= enq_msg;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_deq) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sec08_queues_queue_arbiter.sv
// Round-robin merge of p_nreqs requester streams into one tagged stream.
// Handshake: every stream transfers on a rising clk edge where its val and rdy are
// both high. At most one istream_rdy bit is high (the granted requester, only when
// the buffer has room); ostream is driven purely from the buffer, so there is no
// combinational path from istream_* to ostream_* and istream_rdy ignores ostream_rdy.
module sec08_queues_queue_arbiter
  import sec08_queues_pkg::*;
#(
  parameter int p_nreqs     = c_def_nreqs,
  parameter int p_msg_nbits = c_def_msg_nbits
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [p_nreqs-1:0]                        istream_val,
  output logic [p_nreqs-1:0]                        istream_rdy,
  input  logic [p_nreqs*p_msg_nbits-1:0]            istream_msg,
  output logic                                      ostream_val,
  input  logic                                      ostream_rdy,
  output logic [src_nbits(p_nreqs)+p_msg_nbits-1:0] ostream_msg,
  output logic [1:0]                                num_entries
);

  localparam int c_src_nbits = src_nbits(p_nreqs);
  localparam int c_ent_nbits = c_src_nbits + p_msg_nbits;

  logic [c_src_nbits-1:0] r_ptr;
  logic                   w_grant_val;
  logic [c_src_nbits-1:0] w_grant_idx;
  logic [p_msg_nbits-1:0] w_grant_msg;
  logic [c_ent_nbits-1:0] w_enq_msg;
  logic                   w_enq_rdy;
  logic                   w_enq;

  // Grant search: first valid requester starting at r_ptr, wrapping past the top index.
  always_comb begin
    int idx;
    idx         = 0;
    w_grant_val = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < p_nreqs; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= p_nreqs) idx = idx - p_nreqs;
      if (!w_grant_val && istream_val[idx]) begin
        w_grant_val = 1'b1;
        w_grant_idx = c_src_nbits'(idx);
      end
    end
  end

  // Payload mux for the granted requester, tagged with its source id in the MSBs.
  always_comb begin
    w_grant_msg = '0;
    for (int i = 0; i < p_nreqs; i++) begin
      if (w_grant_idx == c_src_nbits'(i)) w_grant_msg = istream_msg[i*p_msg_nbits +: p_msg_nbits];
    end
    w_enq_msg = {w_grant_idx, w_grant_msg};
  end

  // Single-hot ready back to the granted requester only while the buffer can accept.
  always_comb begin
    istream_rdy = '0;
    w_enq       = w_grant_val && w_enq_rdy;
    if (w_enq) istream_rdy[w_grant_idx] = 1'b1;
  end

  // Priority pointer moves just past the winner on every accepted message; reset favours requester 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_enq) begin
      r_ptr <= (int'(w_grant_idx) == p_nreqs - 1) ? '0 : w_grant_idx + 1'b1;
    end
  end

  sec08_queues_Buf2 #(
    .p_nbits (c_ent_nbits)
  ) u_buf (
    .clk         (clk),
    .reset       (reset),
    .enq_val     (w_grant_val),
    .enq_rdy     (w_enq_rdy),
    .enq_msg     (w_enq_msg),
    .deq_val     (ostream_val),
    .deq_rdy     (ostream_rdy),
    .deq_msg     (ostream_msg),
    .num_entries (num_entries)
  );

endmodule
